serial_to_parallel_inv: RTL

Deserializer that gathers a stream of single-bit inputs into WIDTH-bit words, with optional per-word bit inversion, and presents each word through a valid/ready output register. It sits upstream of the combinational gate/mux exercises and feeds them parallel operand words. It also serves as the team's reference for handshaked sequential stages. Inversion is the same NOT function the mux-based gate implements, applied per word before the word is stored.

---
 rtl/serial_to_parallel_inv_if.sv | 30 +++
 rtl/serial_to_parallel_inv.sv | 92 +++++++++
 2 files changed

// File: rtl/serial_to_parallel_inv_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_to_parallel_inv_if
// Brief   : Serial-in / parallel-out handshake bundle for the deserializer.
// Revision: 1.0 - initial release
// ============================================================================
interface serial_to_parallel_inv_if #(
    parameter int WIDTH = 8
);
    logic             serial_valid;
    logic             serial_data;
    logic             invert;
    logic             serial_ready;
    logic             parallel_valid;
    logic [WIDTH-1:0] parallel_data;
    logic             parallel_ready;
    logic [15:0]      word_count;

    // Upstream bit source and downstream word sink seen as one master
    modport master (
        output serial_valid, serial_data, invert, parallel_ready,
        input  serial_ready, parallel_valid, parallel_data, word_count
    );

    modport slave (
        input  serial_valid, serial_data, invert, parallel_ready,
        output serial_ready, parallel_valid, parallel_data, word_count
    );
endinterface
`default_nettype wire

// File: rtl/serial_to_parallel_inv.sv
`default_nettype none
// ============================================================================
// Module  : serial_to_parallel_inv
// Brief   : MSB-first deserializer with per-word inversion and a valid/ready
//           output register.
// Revision: 1.0 - initial release
// ============================================================================
module serial_to_parallel_inv #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_to_parallel_inv_if.slave io_bus
);
    localparam int            CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [WIDTH-2:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_inv;
    logic [WIDTH-1:0] r_pdata;
    logic             r_pvalid;
    logic [15:0]      r_wcount;

    logic             w_first;
    logic             w_last;
    logic             w_bit;
    logic             w_sready;
    logic             w_accept;
    logic             w_xfer;
    logic             w_complete;
    logic [WIDTH-2:0] w_sh_next;

    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == C_LAST);
    assign w_bit      = io_bus.serial_data ^ (w_first ? io_bus.invert : r_inv);
    // Only the completing bit stalls; earlier bits fill behind a held word
    assign w_sready   = !(w_last && r_pvalid && !io_bus.parallel_ready);
    assign w_accept   = io_bus.serial_valid && w_sready;
    assign w_xfer     = r_pvalid && io_bus.parallel_ready;
    assign w_complete = w_accept && w_last;

    generate
        if (WIDTH > 2) begin : g_shift_wide
            assign w_sh_next = {r_sh[WIDTH-3:0], w_bit};
        end else begin : g_shift_single
            assign w_sh_next = w_bit;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh     <= '0;
            r_cnt    <= '0;
            r_inv    <= 1'b0;
            r_pdata  <= '0;
            r_pvalid <= 1'b0;
            r_wcount <= 16'd0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_inv <= io_bus.invert;
                end
                if (w_last) begin
                    r_pdata <= {r_sh, w_bit};
                    r_cnt   <= '0;
                end else begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt + C_ONE;
                end
            end

            // A completion in the same cycle as a transfer keeps valid high
            if (w_complete) begin
                r_pvalid <= 1'b1;
            end else if (w_xfer) begin
                r_pvalid <= 1'b0;
            end

            if (w_xfer) begin
                r_wcount <= r_wcount + 16'd1;
            end
        end
    end

    assign io_bus.serial_ready   = w_sready;
    assign io_bus.parallel_valid = r_pvalid;
    assign io_bus.parallel_data  = r_pdata;
    assign io_bus.word_count     = r_wcount;
endmodule
`default_nettype wire
